demux3_capture: RTL and testbench
=================================

// Module: demux3_capture
// PURPOSE
//  Write-side counterpart of the 9-channel display read mux. Captures a framed
//  stream of 8-bit RTC bytes (seconds..status, in channel order 0..8) into nine
//  holding registers ch0..ch8 via a valid/ready handshake.
//  Emits one-hot per-channel write strobes and a frame-done pulse.
//  Sits between the RTC bus-read sequencer and the display/selection logic.
// PARAMETERS
//  DW       8      data width of each channel register
//  RST_VAL  8'h00  reset/initial value of every channel register
//  TIMEOUT  255    max idle cycles between accepted bytes inside a frame (1..65535)
// PORTS
//  clk          in   1    system clock, all logic on rising edge
//  reset_n      in   1    asynchronous reset, active low
//  start        in   1    1-cycle pulse: begin (or restart) a 9-byte frame
//  data_in      in   DW   byte from source, meaningful when data_valid=1
//  data_valid   in   1    source has a byte
//  data_ready   out  1    block accepts a byte this cycle (combinational)
//  ch0..ch8     out  DW   channel holding registers
//  wr_onehot    out  9    registered 1-cycle strobe, bit k = ch k just updated
//  busy         out  1    frame in progress
//  done         out  1    1-cycle pulse, frame of 9 bytes completed
//  timeout_err  out  1    1-cycle pulse, frame aborted by watchdog
//  bcd_err      out  1    sticky invalid-BCD flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: ch0..ch8=RST_VAL, wr_onehot=0, busy=0, done=0, timeout_err=0,
//    bcd_err=0, idx=0, wdog=0, state=IDLE. Reset mid-frame discards the frame.
//  - States: IDLE, CAPTURE. busy = (state==CAPTURE), registered.
//  - data_ready = busy & ~start. Handshake = data_valid & data_ready.
//  - IDLE: start -> CAPTURE, idx=0, wdog=0. data_valid ignored.
//  - CAPTURE, handshake at edge N: ch[idx]<=data_in, wr_onehot<=1<<idx, idx++,
//    wdog=0; all visible after edge N (1-cycle latency). Otherwise wr_onehot<=0.
//  - Handshake with idx==8: done<=1 and state<=IDLE at same edge; busy low next cycle.
//  - start during CAPTURE: restart, idx=0, wdog=0, no write that cycle (ready=0);
//    already-written channels keep their values.
//  - Watchdog: wdog increments each CAPTURE cycle without handshake; when it
//    reaches TIMEOUT: timeout_err pulses, state<=IDLE, done not asserted,
//    partially written channels retained. Handshake in that same cycle wins.
//  - start during IDLE clears bcd_err. done/timeout_err never both high.
//  - idx is 4 bits, never exceeds 8; no wrap inside a frame.
// CONFIGURATION
//  Macro DEMUX3_BCD_CHECK_EN:
//  - defined: a byte with either nibble > 4'h9 is stored as 8'h77 (display
//    "invalid" code) instead of data_in; bcd_err set, sticky until next start
//    from IDLE or reset. Strobe/handshake timing unchanged.
//  - undefined: bytes stored unmodified; bcd_err tied 0.
// TESTING
//  1 reset_n low mid-frame -> all ch=RST_VAL, busy=0, wr_onehot=0 within 0 cycles.
//  2 start, then bytes 8'h00..8'h08 back-to-back -> ch k=k, wr_onehot walks
//    001..100 one bit/cycle, done=1 one cycle after 9th handshake, busy=0 next.
//  3 start, 3 bytes, then valid=0 for TIMEOUT cycles -> timeout_err 1 cycle,
//    ch0..ch2 kept, ch3..ch8 unchanged, done never high.
//  4 start, 4 bytes, start again with valid=1 -> ready=0 that cycle, next byte
//    lands in ch0, full frame then completes with done.
//  5 (BCD_CHECK_EN) byte 8'h5A into ch2 -> ch2=8'h77, bcd_err=1 until next start;
//    without macro ch2=8'h5A, bcd_err=0.
//  6 valid toggling every other cycle -> no byte lost/duplicated, wdog never fires.

Source files
------------

// File: rtl/demux3_capture_if.sv
// -----------------------------------------------------------------------------
// demux3_capture_if
// Byte-stream handshake between the RTC bus-read sequencer (master) and the
// demux3_capture block (slave).
//   start       master->slave  1-cycle pulse, begin/restart a 9-byte frame
//   data_in     master->slave  byte, meaningful while data_valid=1
//   data_valid  master->slave  source has a byte
//   data_ready  slave->master  block accepts a byte this cycle
// -----------------------------------------------------------------------------
interface demux3_capture_if #(
  parameter int DW = 8
);
  logic          start;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;

  modport master (
    output start,
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  start,
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/demux3_capture.sv
// -----------------------------------------------------------------------------
// demux3_capture
// Captures a framed stream of nine RTC bytes (seconds..status) into holding
// registers ch0..ch8, in channel order, using a valid/ready handshake.
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous reset, active low
//   s_if         slave side of demux3_capture_if (start/data_in/valid/ready)
//   ch0..ch8     channel holding registers
//   wr_onehot    registered 1-cycle strobe, bit k = ch k just updated
//   busy         frame in progress
//   done         1-cycle pulse, 9-byte frame completed
//   timeout_err  1-cycle pulse, frame aborted by the idle watchdog
//   bcd_err      sticky invalid-BCD flag
// Optional feature macro: DEMUX3_BCD_CHECK_EN
//   defined   -> bytes with a nibble > 9 are stored as 8'h77, bcd_err is set
//                (sticky until the next start from IDLE or reset)
//   undefined -> bytes stored unmodified, bcd_err tied low
// -----------------------------------------------------------------------------
module demux3_capture #(
  parameter int            DW      = 8,
  parameter logic [DW-1:0] RST_VAL = '0,
  parameter int            TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset_n,
  demux3_capture_if.slave s_if,
  output logic [DW-1:0]  ch0,
  output logic [DW-1:0]  ch1,
  output logic [DW-1:0]  ch2,
  output logic [DW-1:0]  ch3,
  output logic [DW-1:0]  ch4,
  output logic [DW-1:0]  ch5,
  output logic [DW-1:0]  ch6,
  output logic [DW-1:0]  ch7,
  output logic [DW-1:0]  ch8,
  output logic [8:0]     wr_onehot,
  output logic           busy,
  output logic           done,
  output logic           timeout_err,
  output logic           bcd_err
);

  typedef enum logic {IDLE, CAPTURE} state_t;

  // Watchdog fires on the idle cycle that brings the count up to TIMEOUT.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   wdog_q, wdog_d;
  logic [DW-1:0] ch_q [0:8];
  logic [DW-1:0] ch_d [0:8];
  logic [8:0]    wr_q, wr_d;
  logic          done_q, done_d;
  logic          to_q, to_d;
  logic          bcd_q, bcd_d;

  logic          handshake;
  logic [DW-1:0] wr_byte;
  logic          byte_bad;

  // Ready drops while start is high so a restart never coincides with a write.
  assign s_if.data_ready = (state_q == CAPTURE) & ~s_if.start;
  assign handshake       = s_if.data_valid & s_if.data_ready;

`ifdef DEMUX3_BCD_CHECK_EN
  assign byte_bad = (s_if.data_in[7:4] > 4'h9) | (s_if.data_in[3:0] > 4'h9);
  assign wr_byte  = byte_bad ? DW'(8'h77) : s_if.data_in;
`else
  assign byte_bad = 1'b0;
  assign wr_byte  = s_if.data_in;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdog_d  = wdog_q;
    wr_d    = '0;
    done_d  = 1'b0;
    to_d    = 1'b0;
    bcd_d   = bcd_q;
    for (int k = 0; k < 9; k++) begin
      ch_d[k] = ch_q[k];
    end

    case (state_q)
      IDLE: begin
        if (s_if.start) begin
          state_d = CAPTURE;
          idx_d   = '0;
          wdog_d  = '0;
          bcd_d   = 1'b0;
        end
      end
      CAPTURE: begin
        if (s_if.start) begin
          // Restart: written channels keep their values.
          idx_d  = '0;
          wdog_d = '0;
        end else if (handshake) begin
          for (int k = 0; k < 9; k++) begin
            if (idx_q == 4'(k)) begin
              ch_d[k] = wr_byte;
              wr_d[k] = 1'b1;
            end
          end
          if (byte_bad) begin
            bcd_d = 1'b1;
          end
          wdog_d = '0;
          if (idx_q == 4'd8) begin
            done_d  = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (wdog_q == WDOG_LAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wdog_q  <= '0;
      wr_q    <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      bcd_q   <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        ch_q[k] <= RST_VAL;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      to_q    <= to_d;
      bcd_q   <= bcd_d;
      for (int k = 0; k < 9; k++) begin
        ch_q[k] <= ch_d[k];
      end
    end
  end

  assign ch0         = ch_q[0];
  assign ch1         = ch_q[1];
  assign ch2         = ch_q[2];
  assign ch3         = ch_q[3];
  assign ch4         = ch_q[4];
  assign ch5         = ch_q[5];
  assign ch6         = ch_q[6];
  assign ch7         = ch_q[7];
  assign ch8         = ch_q[8];
  assign wr_onehot   = wr_q;
  assign busy        = (state_q == CAPTURE);
  assign done        = done_q;
  assign timeout_err = to_q;
`ifdef DEMUX3_BCD_CHECK_EN
  assign bcd_err     = bcd_q;
`else
  assign bcd_err     = 1'b0;
`endif

endmodule

// File: tb/tb_demux3_capture.sv
// -----------------------------------------------------------------------------
// tb_demux3_capture
// Directed bench for demux3_capture with TIMEOUT=5. Inputs change 1 time unit
// after each rising edge; outputs are checked at that same point, i.e. they
// show the state registered by the preceding edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux3_capture;

  localparam int TO = 5;

  logic       clk;
  logic       reset_n;
  logic [7:0] ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7, ch8;
  logic [8:0] wr_onehot;
  logic       busy, done, timeout_err, bcd_err;

  int checks = 0;
  int errors = 0;

  demux3_capture_if #(.DW(8)) s_if ();

  demux3_capture #(
    .DW      (8),
    .RST_VAL (8'h00),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_if        (s_if),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .ch4         (ch4),
    .ch5         (ch5),
    .ch6         (ch6),
    .ch7         (ch7),
    .ch8         (ch8),
    .wr_onehot   (wr_onehot),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .bcd_err     (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_ch(input int k);
    case (k)
      0: return ch0;
      1: return ch1;
      2: return ch2;
      3: return ch3;
      4: return ch4;
      5: return ch5;
      6: return ch6;
      7: return ch7;
      default: return ch8;
    endcase
  endfunction

  // Pulse start for one cycle; after return the block is in CAPTURE.
  task automatic start_frame();
    s_if.start = 1'b1;
    tick();
    s_if.start = 1'b0;
  endtask

  logic [7:0] exp_b;

  initial begin
    reset_n         = 1'b0;
    s_if.start      = 1'b0;
    s_if.data_valid = 1'b0;
    s_if.data_in    = 8'h00;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_wr", wr_onehot, 0);
    chk("rst_done", done, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_bcd", bcd_err, 0);
    chk("rst_ch0", ch0, 8'h00);
    chk("rst_ch8", ch8, 8'h00);
    reset_n = 1'b1;
    tick();

    // Idle: valid ignored, not ready.
    s_if.data_valid = 1'b1;
    #1;
    chk("idle_ready", s_if.data_ready, 0);
    tick();
    chk("idle_wr", wr_onehot, 0);
    s_if.data_valid = 1'b0;

    // Full frame, back-to-back bytes 0..8.
    start_frame();
    chk("f2_busy", busy, 1);
    s_if.data_valid = 1'b1;
    s_if.data_in    = 8'h00;
    #1;
    chk("f2_ready", s_if.data_ready, 1);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("f2_wr%0d", k), wr_onehot, 32'(9'b1 << k));
      chk($sformatf("f2_ch%0d", k), get_ch(k), 32'(k));
      chk($sformatf("f2_done%0d", k), done, (k == 8) ? 1 : 0);
      s_if.data_in = 8'(k + 1);
      if (k == 8) s_if.data_valid = 1'b0;
    end
    chk("f2_busy_end", busy, 0);
    tick();
    chk("f2_done_clr", done, 0);
    chk("f2_wr_clr", wr_onehot, 0);

    // Watchdog: 3 bytes then idle.
    start_frame();
    s_if.data_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_if.data_in = 8'h11 * 8'(k + 1);
      tick();
    end
    s_if.data_valid = 1'b0;
    chk("f3_ch2", ch2, 8'h33);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk($sformatf("f3_to_early%0d", k), timeout_err, 0);
      chk($sformatf("f3_busy%0d", k), busy, 1);
    end
    tick();
    chk("f3_to", timeout_err, 1);
    chk("f3_done", done, 0);
    chk("f3_busy_end", busy, 0);
    tick();
    chk("f3_to_clr", timeout_err, 0);
    chk("f3_ch0", ch0, 8'h11);
    chk("f3_ch1", ch1, 8'h22);
    chk("f3_ch3", ch3, 8'h03);
    chk("f3_ch8", ch8, 8'h08);

    // Restart mid-frame.
    start_frame();
    s_if.data_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_if.data_in = 8'hA0 + 8'(k);
      tick();
    end
    chk("f4_ch3", ch3, 8'hA3);
    s_if.start   = 1'b1;
    s_if.data_in = 8'hB0;
    #1;
    chk("f4_ready_start", s_if.data_ready, 0);
    tick();
    s_if.start = 1'b0;
    chk("f4_wr_none", wr_onehot, 0);
    chk("f4_ch0_keep", ch0, 8'hA0);
    for (int k = 0; k < 9; k++) begin
      s_if.data_in = 8'hC0 + 8'(k);
      tick();
      chk($sformatf("f4_c%0d", k), get_ch(k), 32'(8'hC0 + 8'(k)));
    end
    s_if.data_valid = 1'b0;
    chk("f4_done", done, 1);

    // Valid toggling every other cycle.
    start_frame();
    for (int k = 0; k < 9; k++) begin
      s_if.data_valid = 1'b1;
      s_if.data_in    = 8'h40 + 8'(k);
      tick();
      chk($sformatf("f6_wr%0d", k), wr_onehot, 32'(9'b1 << k));
      s_if.data_valid = 1'b0;
      if (k != 8) begin
        tick();
        chk($sformatf("f6_gap%0d", k), wr_onehot | {8'h0, timeout_err}, 0);
      end
    end
    chk("f6_done", done, 1);
    chk("f6_ch5", ch5, 8'h45);
    chk("f6_ch8", ch8, 8'h48);

    // Invalid BCD byte into ch2.
    start_frame();
    s_if.data_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      s_if.data_in = (k == 2) ? 8'h5A : 8'h09;
      tick();
    end
    s_if.data_valid = 1'b0;
    chk("f5_done", done, 1);
`ifdef DEMUX3_BCD_CHECK_EN
    exp_b = 8'h77;
    chk("f5_bcd_sticky", bcd_err, 1);
`else
    exp_b = 8'h5A;
    chk("f5_bcd_sticky", bcd_err, 0);
`endif
    chk("f5_ch2", ch2, exp_b);
    chk("f5_ch3", ch3, 8'h09);
    start_frame();
    chk("f5_bcd_clr", bcd_err, 0);

    // Asynchronous reset mid-frame, right after a write strobe.
    s_if.data_valid = 1'b1;
    s_if.data_in    = 8'h21;
    tick();
    chk("f1_wr_pre", wr_onehot, 9'h001);
    reset_n = 1'b0;
    #1;
    chk("f1_busy", busy, 0);
    chk("f1_wr", wr_onehot, 0);
    chk("f1_ch0", ch0, 8'h00);
    chk("f1_ch4", ch4, 8'h00);
    s_if.data_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("f1_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
